// File: rtl/arb_pkg.sv
// Shared constants for the round-robin grant scheduler: requester count,
// index width, default hold limit and the two FSM state codes.
package arb_pkg;
    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HOLD_W       = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

// File: rtl/rr_prio_enc.sv
// Rotated priority encoder: the first set req bit found searching upward
// from ptr, wrapping past the top requester.
module rr_prio_enc
    import arb_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = IDX_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    // N is a power of two, so the W-bit sum wraps by itself.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[ptr + W'(i)]) begin
                idx   = ptr + W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: one owner at a time, ended by release, request
// drop or a hold limit, with a guaranteed idle cycle between grants.
module rr_grant_sched #(
    parameter int N_REQ    = arb_pkg::N_REQ,
    parameter int IDX_W    = arb_pkg::IDX_W,
    parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);
    import arb_pkg::*;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_found;
    logic             owner_req, expire, grant_end;

    rr_prio_enc #(.N(N_REQ), .W(IDX_W)) u_enc (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (enc_idx),
        .found (enc_found)
    );

    assign owner_req = req[idx_q];
    assign expire    = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign grant_end = release_i | ~owner_req | expire;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (enc_found) begin
                    state_d = ST_GRANT;
                    idx_d   = enc_idx;
                    gnt_d   = N_REQ'(1) << enc_idx;
                    hold_d  = '0;
                end
            end
            default: begin
                if (grant_end) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    ptr_d     = idx_q + IDX_W'(1);
                    // A voluntary end on the expiry cycle is not a forced revoke.
                    timeout_d = expire & ~release_i & owner_req;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = (state_q == ST_GRANT);
    assign timeout = timeout_q;
endmodule

// File: tb/tb_rr_grant_sched.sv
// Bench for rr_grant_sched: directed scenarios plus a random run against a
// queue-free behavioural model of owner / pointer / hold time.
module tb_rr_grant_sched;
    localparam int N  = 8;
    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    bit m_busy;
    int m_owner, m_ptr, m_hold;
    bit m_tmo;

    rr_grant_sched #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .release_i (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_tmo = 0;
    endfunction

    function automatic void model_edge();
        m_tmo = 0;
        if (!m_busy) begin
            for (int j = 0; j < N; j++) begin
                int k;
                k = (m_ptr + j) % N;
                if (!m_busy && req[k]) begin
                    m_owner = k; m_busy = 1; m_hold = 0;
                end
            end
        end else if (rel || !req[m_owner] || m_hold == MH - 1) begin
            m_tmo  = (m_hold == MH - 1) && !rel && req[m_owner];
            m_ptr  = (m_owner + 1) % N;
            m_busy = 0;
        end else begin
            m_hold++;
        end
    endfunction

    function automatic logic [7:0] exp_gnt();
        logic [7:0] one;
        one = 8'h01;
        return m_busy ? (one << m_owner) : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rel = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; rel = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%h idx=%0d vld=%b tmo=%b want all 0", gnt, gnt_idx, gnt_vld, timeout);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h10;
        tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd4 || gnt !== 8'h10) begin
            errors++;
            $display("FAIL single_grant: got vld=%b idx=%0d gnt=%h want 1/4/10", gnt_vld, gnt_idx, gnt);
        end
        tick(); tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd4 || gnt !== 8'h10) begin
            errors++;
            $display("FAIL single_hold: got vld=%b idx=%0d gnt=%h want 1/4/10", gnt_vld, gnt_idx, gnt);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt_vld !== 1'b0 || gnt !== 8'h00 || gnt_idx !== 3'd4) begin
            errors++;
            $display("FAIL single_drop: got vld=%b idx=%0d gnt=%h want 0/4/00", gnt_vld, gnt_idx, gnt);
        end
        req = 8'h21;
        tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd5) begin
            errors++;
            $display("FAIL single_ptr: got vld=%b idx=%0d want 1/5", gnt_vld, gnt_idx);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] one;
        one = 8'h01;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (gnt_vld !== 1'b1 || gnt_idx !== 3'(i % 8) || gnt !== (one << (i % 8))) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got vld=%b idx=%0d gnt=%h want idx %0d", i, gnt_vld, gnt_idx, gnt, i % 8);
            end
            rel = 1'b1;
            tick();
            rel = 1'b0;
            checks++;
            if (gnt_vld !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap[%0d]: got vld=%b want 0", i, gnt_vld);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        req = 8'h01;
        tick();
        hi = 0;
        while (gnt_vld === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        checks++;
        if (hi != MH || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_len: got high=%0d tmo=%b want %0d/1", hi, timeout, MH);
        end
        tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: got vld=%b idx=%0d tmo=%b want 1/0/0", gnt_vld, gnt_idx, timeout);
        end
        req = 8'h00;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 8'h01;
        tick();
        repeat (MH - 1) tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        checks++;
        if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL expiry_release: got vld=%b tmo=%b want 0/0", gnt_vld, timeout);
        end
        req = 8'h00; rel = 1'b1;
        tick();
        rel = 1'b0;
        checks++;
        if (gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL idle_release: got vld=%b idx=%0d tmo=%b want 0/0/0", gnt_vld, gnt_idx, timeout);
        end
        req = 8'hFF;
        tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd1) begin
            errors++;
            $display("FAIL idle_release_ptr: got vld=%b idx=%0d want 1/1", gnt_vld, gnt_idx);
        end
        req = 8'h00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h20;
        tick();
        rel = 1'b1;
        tick();
        rel = 1'b0; req = 8'h40;
        tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd6) begin
            errors++;
            $display("FAIL midrst_setup: got vld=%b idx=%0d want 1/6", gnt_vld, gnt_idx);
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 13'h0) begin
            errors++;
            $display("FAIL midrst_async: got gnt=%h idx=%0d vld=%b tmo=%b want all 0", gnt, gnt_idx, gnt_vld, timeout);
        end
        #2;
        rst = 1'b0; req = 8'hC1;
        tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ptr0: got vld=%b idx=%0d tmo=%b want 1/0/0", gnt_vld, gnt_idx, timeout);
        end
        req = 8'hC0; rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        checks++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 3'd6) begin
            errors++;
            $display("FAIL midrst_c0: got vld=%b idx=%0d want 1/6", gnt_vld, gnt_idx);
        end
        req = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] one;
        one = 8'h01;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            // Second half keeps the owner requesting so forced revokes occur.
            if (i < 250) begin
                if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
                rel = ($urandom_range(0, 7) == 0);
            end else begin
                req = 8'($urandom) & 8'($urandom);
                if (m_busy) req = req | (one << m_owner);
                rel = ($urandom_range(0, 31) == 0);
            end
            tick();
            checks++;
            if (gnt_vld !== m_busy || gnt !== exp_gnt() || gnt_idx !== 3'(m_owner) || timeout !== m_tmo) begin
                errors++;
                $display("FAIL random[%0d]: got vld=%b gnt=%h idx=%0d tmo=%b want %b/%h/%0d/%b",
                         i, gnt_vld, gnt, gnt_idx, timeout, m_busy, exp_gnt(), m_owner, m_tmo);
            end
            if (gnt_vld === 1'b1) begin
                checks++;
                if (!$onehot(gnt) || gnt[gnt_idx] !== 1'b1) begin
                    errors++;
                    $display("FAIL encoding[%0d]: got gnt=%h idx=%0d want one-hot at idx", i, gnt, gnt_idx);
                end
            end
        end
        req = 8'h00; rel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_grant_sched.md
RR_GRANT_SCHED -- requirements
Module: rr_grant_sched

Interface
REQ-001 Parameter N_REQ, default 8: number of requesters; fixed at 8 in this revision.
REQ-002 Parameter IDX_W, default 3: width of the grant index; equals log2(N_REQ).
REQ-003 Parameter MAX_HOLD, default 16: maximum grant length in cycles before a forced revoke; legal range 2..255.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port req, input, N_REQ: request lines, one per requester, level-sensitive.
REQ-007 Port release, input, 1: the current owner ends its grant.
REQ-008 Port gnt, output, N_REQ: registered one-hot grant vector.
REQ-009 Port gnt_idx, output, IDX_W: registered binary index of the granted requester.
REQ-010 Port gnt_vld, output, 1: registered; high while a grant is held.
REQ-011 Port timeout, output, 1: registered one-cycle pulse on a forced revoke.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-013 In IDLE with req nonzero, the block SHALL enter GRANT at the next edge.
- It SHALL select the first set req bit found by searching circularly upward from the priority pointer ptr (ptr, ptr+1, ..., 7, 0, ...).
- Latency is 1 cycle: gnt_vld rises on the edge that samples the request.
REQ-014 In IDLE with req zero, the block SHALL remain in IDLE with gnt_vld=0, gnt=0 and gnt_idx holding its last value.
REQ-015 In GRANT, gnt SHALL equal 1<<gnt_idx, and gnt and gnt_idx SHALL stay stable until the grant ends.
REQ-016 A grant SHALL end at the next edge on any of these conditions:
- release=1;
- req[gnt_idx]=0;
- hold counter = MAX_HOLD-1.
REQ-017 On grant end, the block SHALL set ptr = (gnt_idx+1) mod N_REQ, wrapping 7 to 0, and return to IDLE.
- gnt_vld=0 for at least one cycle between consecutive grants.
REQ-018 The hold counter SHALL clear on entry to GRANT and increment by 1 each GRANT cycle; the first grant cycle counts as 0.
REQ-019 timeout SHALL pulse high for exactly one cycle, only when the grant ends by counter expiry with release=0 and req[gnt_idx]=1.
- release or req drop on the expiry cycle takes precedence: no timeout pulse.
REQ-020 release while in IDLE SHALL be ignored.
REQ-021 Requests from non-owners during GRANT SHALL be ignored until the next IDLE cycle; no preemption.
REQ-022 The index and one-hot grant SHALL always be consistent: gnt_idx is the binary encoding of gnt whenever gnt_vld=1.

Reset
REQ-023 Asserting rst SHALL immediately force:
- state=IDLE;
- gnt=0, gnt_idx=0, gnt_vld=0, timeout=0;
- ptr=0 and hold counter=0.
REQ-024 Reset asserted mid-grant SHALL abort the grant with no timeout pulse.
- The first arbitration after reset release SHALL start from ptr=0.

Structure
REQ-025 A shared package arb_pkg SHALL hold N_REQ, IDX_W, the default MAX_HOLD and the FSM state enumeration.
REQ-026 The circular search SHALL be one combinational sub-module, rr_prio_enc.
- Inputs: req and ptr.
- Outputs: a 3-bit index and a found flag.
- It is an 8-to-3 priority encoder with a rotated start point.
- The top level holds all registers.

Verification
REQ-027 Single request: reset, then req=8'b0001_0000 for 3 cycles, then 0 -> gnt_vld high 1 cycle after sampling, gnt_idx=4, gnt=8'h10; ends when req drops; ptr becomes 5.
REQ-028 Round-robin and wrap: req=8'hFF held, release pulsed once per grant -> gnt_idx sequence 0,1,...,7,0, with a 1-cycle gnt_vld gap between grants.
REQ-029 Timeout: MAX_HOLD=16, req=8'h01 held, no release -> gnt_vld high exactly 16 cycles, timeout pulses once on the revoke edge, regrant to 0 after 1 idle cycle.
REQ-030 Simultaneous events: on the expiry cycle drive release=1 -> grant ends with timeout=0; release in IDLE -> no state change.
REQ-031 Reset mid-grant: grant to idx 6 (ptr at 6), assert rst asynchronously mid-cycle -> all outputs 0 immediately; after release of rst with req=8'hC0, gnt_idx=6 (search from ptr=0).
REQ-032 Encoding check: every cycle with gnt_vld=1, gnt shall be one-hot and gnt_idx shall equal its bit position, across a 500-cycle random req/release run.
